// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush wins over push.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding word requests, queues
// returned instructions for decode and handles redirects by flushing.
//
//   state      | meaning
//   -----------+------------------------------------------------
//   FETCH_IDLE | nothing outstanding, may request
//   FETCH_WAIT | one response pending, data will be queued
//   FETCH_DROP | one response pending, data will be discarded
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            grant;
    logic            push;
    logic            pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]  credit;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            if (state_q != FETCH_IDLE) begin
                state_d = imem_rvalid_i ? FETCH_IDLE : FETCH_DROP;
            end
        end else begin
            case (state_q)
                FETCH_IDLE: if (grant) state_d = FETCH_WAIT;
                FETCH_WAIT: if (imem_rvalid_i) state_d = grant ? FETCH_WAIT : FETCH_IDLE;
                FETCH_DROP: if (imem_rvalid_i) state_d = FETCH_IDLE;
                default:    state_d = FETCH_IDLE;
            endcase
        end
    end

    // The in-flight request reserves a slot; a same-cycle pop does not free one.
    assign credit = {1'b0, fifo_count} + (CNT_W + 1)'(state_q == FETCH_WAIT);

    always_comb begin
        imem_req_o = 1'b0;
        push       = 1'b0;
        if (!rst_i && !redirect_i) begin
            if ((state_q == FETCH_IDLE || (state_q == FETCH_WAIT && imem_rvalid_i)) &&
                (credit < (CNT_W + 1)'(DEPTH))) begin
                imem_req_o = 1'b1;
            end
            push = (state_q == FETCH_WAIT) && imem_rvalid_i;
        end
    end

    assign grant       = imem_req_o && imem_gnt_i;
    assign imem_addr_o = pc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else if (redirect_i) begin
            pc_q <= align_word(redirect_pc_i);
        end else if (grant) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + PC_STEP;
        end
    end

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};
    assign pop        = instr_valid_o && instr_ready_i;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (redirect_i),
        .count      (fifo_count),
        .head_valid (instr_valid_o),
        .head       (head_entry)
    );

    assign instr_o    = head_entry.instr;
    assign instr_pc_o = head_entry.pc;

endmodule
